// File: rtl/rf_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter and its
// long-latency result queue.
package rf_write_arbiter_pkg;

    localparam int DATA_W     = 32;
    localparam int FIFO_DEPTH = 2;

    typedef logic [4:0] rf_idx_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_WAIT,
        ARB_STALL
    } arb_state_t;

    typedef struct packed {
        rf_idx_t             rd;
        logic [DATA_W-1:0]   data;
    } wr_ent_t;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bundle of writeback, long-latency result and register-file write signals.
// The slave modport is the arbiter's view; master is the surrounding pipeline.
interface rf_write_arbiter_if;

    logic                                 wb_we_i;
    rf_write_arbiter_pkg::rf_idx_t        wb_rd_i;
    logic [31:0]                          wb_data_i;
    logic                                 md_valid_i;
    rf_write_arbiter_pkg::rf_idx_t        md_rd_i;
    logic [31:0]                          md_data_i;
    logic                                 md_ready_o;
    logic                                 stall_o;
    logic [31:0]                          pend_mask_o;
    logic                                 rf_we_o;
    rf_write_arbiter_pkg::rf_idx_t        rf_rd_o;
    logic [31:0]                          rf_data_o;

    modport slave (
        input  wb_we_i, wb_rd_i, wb_data_i,
        input  md_valid_i, md_rd_i, md_data_i,
        output md_ready_o, stall_o, pend_mask_o,
        output rf_we_o, rf_rd_o, rf_data_o
    );

    modport master (
        output wb_we_i, wb_rd_i, wb_data_i,
        output md_valid_i, md_rd_i, md_data_i,
        input  md_ready_o, stall_o, pend_mask_o,
        input  rf_we_o, rf_rd_o, rf_data_o
    );

endinterface

// File: rtl/rf_wr_fifo.sv
// Two-entry in-order queue of long-latency results with a same-cycle
// squash port that removes every entry aimed at a given register.
module rf_wr_fifo
    import rf_write_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_enq,
    input  wr_ent_t     i_enq_ent,
    input  logic        i_deq,
    input  logic        i_sq,
    input  rf_idx_t     i_sq_rd,
    output logic        o_head_vld,
    output wr_ent_t     o_head,
    output logic [1:0]  o_count,
    output logic [31:0] o_pend_mask
);

    logic [FIFO_DEPTH-1:0] r_vld;
    wr_ent_t               r_ent0;
    wr_ent_t               r_ent1;

    logic                  w_keep0;
    logic                  w_keep1;
    logic [FIFO_DEPTH-1:0] w_vld_nxt;
    wr_ent_t               w_ent0_nxt;
    wr_ent_t               w_ent1_nxt;

    // Entries stay packed toward slot 0: drop dequeued/squashed ones, close
    // the gap, then append the new result behind whatever survived.
    always_comb begin
        w_keep0    = r_vld[0] && !i_deq && !(i_sq && (r_ent0.rd == i_sq_rd));
        w_keep1    = r_vld[1] && !(i_sq && (r_ent1.rd == i_sq_rd));
        w_vld_nxt  = {w_keep0 && w_keep1, w_keep0 || w_keep1};
        w_ent0_nxt = w_keep0 ? r_ent0 : r_ent1;
        w_ent1_nxt = r_ent1;
        if (i_enq) begin
            if (!w_vld_nxt[0]) begin
                w_ent0_nxt   = i_enq_ent;
                w_vld_nxt[0] = 1'b1;
            end else begin
                w_ent1_nxt   = i_enq_ent;
                w_vld_nxt[1] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
        end else begin
            r_vld <= w_vld_nxt;
        end
    end

    always_ff @(posedge clk) begin
        r_ent0 <= w_ent0_nxt;
        r_ent1 <= w_ent1_nxt;
    end

    always_comb begin
        o_pend_mask = '0;
        if (r_vld[0]) o_pend_mask[r_ent0.rd] = 1'b1;
        if (r_vld[1]) o_pend_mask[r_ent1.rd] = 1'b1;
        o_pend_mask[0] = 1'b0;
    end

    assign o_head_vld = r_vld[0];
    assign o_head     = r_ent0;
    assign o_count    = {r_vld[1], r_vld[0] & ~r_vld[1]};

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write port arbiter: pipeline writeback always wins, queued
// mul/div results fill the gaps, and a starvation FSM requests a bubble.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               rst,
    rf_write_arbiter_if.slave bus
);

    logic        w_wb_vld;
    logic        w_head_vld;
    wr_ent_t     w_head;
    logic [1:0]  w_count;
    logic        w_grant_md;
    logic        w_md_ready;
    logic        w_enq;
    wr_ent_t     w_enq_ent;
    logic        w_blocked;
    logic [3:0]  w_cnt_inc;
    logic [31:0] w_pend_mask;

    arb_state_t  r_state;
    arb_state_t  w_state_nxt;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_nxt;

    logic        r_rf_we;
    rf_idx_t     r_rf_rd;
    logic [31:0] r_rf_data;

    assign w_wb_vld   = bus.wb_we_i && (bus.wb_rd_i != '0);
    assign w_grant_md = !w_wb_vld && w_head_vld;
    assign w_blocked  = w_head_vld && w_wb_vld;
    assign w_md_ready = (w_count < 2'(FIFO_DEPTH)) || w_grant_md;
    // x0 results complete the handshake but are never queued.
    assign w_enq      = bus.md_valid_i && w_md_ready && (bus.md_rd_i != '0);
    assign w_enq_ent  = {bus.md_rd_i, bus.md_data_i};

    rf_wr_fifo u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_enq       (w_enq),
        .i_enq_ent   (w_enq_ent),
        .i_deq       (w_grant_md),
        .i_sq        (w_wb_vld),
        .i_sq_rd     (bus.wb_rd_i),
        .o_head_vld  (w_head_vld),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_pend_mask (w_pend_mask)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rf_we   <= 1'b0;
            r_rf_rd   <= '0;
            r_rf_data <= '0;
        end else if (w_wb_vld) begin
            r_rf_we   <= 1'b1;
            r_rf_rd   <= bus.wb_rd_i;
            r_rf_data <= bus.wb_data_i;
        end else if (w_grant_md) begin
            r_rf_we   <= 1'b1;
            r_rf_rd   <= w_head.rd;
            r_rf_data <= w_head.data;
        end else begin
            r_rf_we   <= 1'b0;
            r_rf_rd   <= '0;
            r_rf_data <= '0;
        end
    end

    assign w_cnt_inc = {1'b0, r_cnt} + 4'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            ARB_IDLE: begin
                if (w_blocked) begin
                    w_state_nxt = ARB_WAIT;
                    w_cnt_nxt   = 3'd1;
                end
            end
            ARB_WAIT: begin
                if (!w_head_vld || w_grant_md) begin
                    w_state_nxt = ARB_IDLE;
                    w_cnt_nxt   = 3'd0;
                end else if (w_cnt_inc >= 4'(STARVE_LIMIT)) begin
                    w_state_nxt = ARB_STALL;
                    w_cnt_nxt   = w_cnt_inc[2:0];
                end else begin
                    w_cnt_nxt   = w_cnt_inc[2:0];
                end
            end
            ARB_STALL: begin
                if (w_blocked) begin
                    w_state_nxt = ARB_WAIT;
                    w_cnt_nxt   = 3'd1;
                end else begin
                    w_state_nxt = ARB_IDLE;
                    w_cnt_nxt   = 3'd0;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
                w_cnt_nxt   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ARB_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign bus.md_ready_o  = w_md_ready;
    assign bus.stall_o     = (r_state == ARB_STALL);
    assign bus.pend_mask_o = w_pend_mask;
    assign bus.rf_we_o     = r_rf_we;
    assign bus.rf_rd_o     = r_rf_rd;
    assign bus.rf_data_o   = r_rf_data;

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, is the number of consecutive blocked cycles with a queued long-latency result before a stall request is raised.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 wb_we_i  input  1  pipeline writeback write request; highest priority; never back-pressured.
REQ-005 wb_rd_i  input  5  pipeline destination register.
REQ-006 wb_data_i  input  32  pipeline write data.
REQ-007 md_valid_i  input  1  long-latency unit (mul/div) result valid.
REQ-008 md_rd_i  input  5  long-latency destination register.
REQ-009 md_data_i  input  32  long-latency result data.
REQ-010 md_ready_o  output  1  arbiter can accept a long-latency result this cycle.
REQ-011 stall_o  output  1  registered request to the pipeline to insert a writeback bubble.
REQ-012 pend_mask_o  output  32  bit n set while a queued entry targets register n; bit 0 always 0.
REQ-013 rf_we_o, rf_rd_o[4:0], rf_data_o[31:0]  output  register-file write port, all registered.

Function
REQ-014 A wb request with wb_rd_i = 0 is treated as no request.
REQ-015 A md transfer occurs when md_valid_i and md_ready_o are both high; md_rd_i = 0 is accepted and discarded.
REQ-016 Accepted md results enter a 2-entry in-order FIFO.
REQ-017 md_ready_o is high when the FIFO holds fewer than 2 entries, or when it is full and its head is granted this cycle.
REQ-018 Grant, per cycle: a valid wb request wins; otherwise the FIFO head wins if present; otherwise there is no write.
REQ-019 The write port registers the granted rd and data with 1-cycle latency: rf_we_o is high in cycle N+1 for a grant in cycle N; with no grant rf_we_o = 0 and rf_rd_o = rf_data_o = 0.
REQ-020 A md result accepted in cycle N is granted no earlier than cycle N+1; there is no FIFO bypass.
REQ-021 WAW squash: a valid wb request for rd r deletes every FIFO entry with rd r in the same cycle, because the pipeline write is younger.
REQ-022 A md result arriving in the same cycle as a matching wb rd is enqueued, not squashed.
REQ-023 Simultaneous enqueue, dequeue and squash in one cycle shall leave a correct count (0..2) and order.
REQ-024 pend_mask_o is combinational from the FIFO contents after the current-cycle state, i.e. it reflects registered FIFO state.
REQ-025 Starvation FSM has states IDLE, WAIT and STALL, with a 3-bit blocked counter.
REQ-026 IDLE: move to WAIT when the FIFO is non-empty and the head is blocked by wb; the counter is set to 1.
REQ-027 WAIT: the counter increments on each blocked cycle; return to IDLE if the FIFO empties or the head is granted; move to STALL when the counter reaches STARVE_LIMIT.
REQ-028 STALL: stall_o = 1 for exactly one cycle, then return to IDLE; if wb still writes in the cycle after the stall, wb still wins and the FSM re-enters WAIT.
REQ-029 stall_o is 0 in IDLE and in WAIT.

Reset
REQ-030 While rst is high: FIFO empty, FSM in IDLE, counter 0, and rf_we_o, rf_rd_o, rf_data_o, stall_o, pend_mask_o all 0; md_ready_o = 1.
REQ-031 Reset asserted mid-operation discards all queued results with no partial write; the first write after deassertion occurs no earlier than 1 cycle after a new grant.

Structure
REQ-032 A shared package holds the FSM state enum (ARB_IDLE, ARB_WAIT, ARB_STALL), the 5-bit register-index typedef and the FIFO depth constant 2.
REQ-033 The FIFO, including its squash port, is one sub-module named rf_wr_fifo; arbitration and the FSM live in the top module.

Verification
REQ-034 Single md result, no wb: md rd=7, data=0xDEADBEEF accepted in cycle 0 -> rf_we_o=1, rf_rd_o=7, rf_data_o=0xDEADBEEF in cycle 2; pend_mask_o bit 7 set in cycle 1 only.
REQ-035 Conflict: wb rd=3 and md rd=4 in the same cycle -> rd 3 written first, rd 4 written the next cycle, no data loss.
REQ-036 Backpressure: three md results in consecutive cycles while wb writes continuously -> md_ready_o drops after 2 accepted; the third is held until a slot frees.
REQ-037 Starvation: FIFO head blocked by wb for 4 cycles with STARVE_LIMIT=4 -> stall_o high for exactly 1 cycle; a wb bubble next cycle -> head written.
REQ-038 WAW squash: FIFO holds rd=9, then wb rd=9 data=0x1 -> only 0x1 is written to rd 9; FIFO empty; pend_mask_o bit 9 cleared.
REQ-039 x0 and reset: md rd=0 accepted and never written; rst pulsed with 2 entries queued -> all outputs 0 and no write after release.
